ct_f_spsram_512x144_arb: RTL and testbench
==========================================

Name: ct_f_spsram_512x144_arb

Overview:
- Two-requester arbiter and init sequencer in front of one ct_f_spsram_512x144 single-port SRAM in the FPGA build.
- After reset, or on request, it clears all 512 entries to zero.
- After that it grants one read or write per cycle, using round-robin between requester 0 and requester 1.
- It drives the SRAM's active-low CEN/GWEN/WEN pins and returns read data with fixed one-cycle latency.

Parameters:
- ADDR_WIDTH, 9, SRAM address width; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 144, SRAM data width and bit-mask width.

Ports:
- CLK  in  1  clock, shared with the SRAM.
- RST  in  1  asynchronous, active-high reset.
- clr_req  in  1  pulse: re-run the zero-fill sweep.
- init_done  out  1  high when in RUN (sweep complete).
- rq_vld[1:0]  in  2  per-requester request valid.
- rq_rdy[1:0]  out  2  per-requester grant; a transfer happens when vld & rdy.
- rq0_wr, rq1_wr  in  1 each  1 = write, 0 = read.
- rq0_addr, rq1_addr  in  ADDR_WIDTH each  access address.
- rq0_wdata, rq1_wdata  in  DATA_WIDTH each  write data.
- rq0_wmask, rq1_wmask  in  DATA_WIDTH each  active-high per-bit write enable.
- rsp_vld[1:0]  out  2  read-data valid, one-cycle pulse per read.
- rsp_data  out  DATA_WIDTH  read data; meaningful only when an rsp_vld bit is high.
- sram_a  out  ADDR_WIDTH  to SRAM A.
- sram_cen  out  1  to SRAM CEN (active low).
- sram_gwen  out  1  to SRAM GWEN (active low).
- sram_wen  out  DATA_WIDTH  to SRAM WEN (active low, per bit).
- sram_d  out  DATA_WIDTH  to SRAM D.
- sram_q  in  DATA_WIDTH  from SRAM Q.

Behaviour:
- Reset values (asynchronous on RST):
  - state = INIT, init counter = 0, rr pointer = 0 (requester 0 favoured first).
  - rsp_vld = 0, init_done = 0.
  - SRAM pins held idle while RST is high: sram_cen = 1, sram_gwen = 1, sram_wen = all 1.
- States are INIT and RUN.
- INIT:
  - Each cycle writes zero to address = counter: cen = 0, gwen = 0, wen = all 0, d = 0.
  - rq_rdy = 0; counter increments.
  - After the write at 2**ADDR_WIDTH-1 (512 cycles), go to RUN. init_done rises in the next cycle.
  - clr_req during INIT is ignored.
- RUN, SRAM pins and grant:
  - SRAM pins are combinational from the granted request.
  - Grant rule: only one requester valid → that one is granted. Both valid → the one not granted last time is granted.
  - The rr pointer updates only on an actual grant.
  - Write: gwen = 0, wen = ~wmask, d = wdata.
  - Read: gwen = 1, wen = all 1.
  - No grant: cen = 1.
  - rq_rdy is combinational and may depend on rq_vld. Requesters must not make vld depend on rdy.
- RUN, read response:
  - rsp_vld[i] is registered high exactly one cycle after a read accept by requester i.
  - rsp_data = sram_q passthrough.
  - Back-to-back reads give back-to-back responses.
- Write to read ordering:
  - A write in cycle N followed by a read of the same address in cycle N+1 returns the new data.
  - The SRAM is single-port, so there is no bypass logic.
- clr_req in RUN:
  - In that cycle rq_rdy = 0 and no access is issued.
  - Next cycle: state = INIT, counter = 0, init_done = 0.
  - A read accepted in the prior cycle still produces its rsp_vld.
- wmask = 0 write: consumes a slot with cen = 0, gwen = 0, wen = all 1. Memory is unchanged and it counts as a grant.
- Reset mid-sweep: the sweep restarts from address 0.

Decomposition:
- Package ct_f_spsram_arb_pkg holds:
  - state enum {INIT, RUN};
  - localparam DEPTH = 512;
  - the request struct type (wr, addr, wdata, wmask).
- Sub-module ct_f_rr_arb2 holds the 2-way round-robin pick plus its pointer flop. It has the same CLK/RST convention.

Test Plan:
- Reset, then hold idle → init_done rises 513 cycles after RST falls; a spot read of addrs 0, 255 and 511 returns 0.
- After init: requester 0 writes addr 0x1A5, data 0xDEADBEEF_00 (zero-extended to 144 bits), mask all-1; next cycle it reads 0x1A5 → rsp_vld[0] one cycle after accept, rsp_data = 0xDEADBEEF_00.
- Both requesters hold vld for 6 cycles with reads to 0x010 / 0x020 → grants alternate 0,1,0,1,0,1; each rsp_vld bit pulses accordingly with the correct data.
- Masked write: write all-1s with mask = 0x0000…00FF at addr 5, then read → low 8 bits = 0xFF, others unchanged (0).
- After writing 0x3 to addr 7, pulse clr_req while requester 1 holds vld → rq_rdy = 0 for 513 cycles, then the grant resumes and a read of addr 7 returns 0.
- Assert RST at sweep counter = 100 → SRAM idles, rsp_vld = 0; after release the sweep restarts at address 0 (sram_a = 0 in the first cycle).

Source files
------------

// File: rtl/ct_f_spsram_arb_pkg.sv
// Shared types for the 512x144 SPSRAM arbiter.
// State enum, depth and the per-requester request bundle.
package ct_f_spsram_arb_pkg;

  localparam int REQ_AW = 9;
  localparam int REQ_DW = 144;
  localparam int DEPTH  = 512;

  typedef enum logic {
    INIT,
    RUN
  } state_e;

  typedef struct packed {
    logic              wr;
    logic [REQ_AW-1:0] addr;
    logic [REQ_DW-1:0] wdata;
    logic [REQ_DW-1:0] wmask;
  } req_t;

endpackage

// File: rtl/ct_f_rr_arb2.sv
// Two-way round-robin pick with its favour pointer.
// Ports: CLK, RST, en (allow grants), vld[1:0] in, gnt[1:0] out.
module ct_f_rr_arb2 (
  input  logic       CLK,
  input  logic       RST,
  input  logic       en,
  input  logic [1:0] vld,
  output logic [1:0] gnt
);

  // Requester that wins when both are valid.
  logic ptr;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      unique case (1'b1)
        (vld == 2'b11): gnt = ptr ? 2'b10 : 2'b01;
        (vld == 2'b01): gnt = 2'b01;
        (vld == 2'b10): gnt = 2'b10;
        default:        gnt = 2'b00;
      endcase
    end
  end

  // Winner 0 hands the favour to 1 and vice versa.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ptr <= 1'b0;
    end else if (|gnt) begin
      ptr <= gnt[0];
    end
  end

endmodule

// File: rtl/ct_f_spsram_512x144_arb.sv
// Init sweep + 2-requester round-robin front end for one 512x144 SPSRAM.
// Ports: CLK/RST, clr_req, init_done, rq*, rsp_vld/rsp_data, sram_* pins.
module ct_f_spsram_512x144_arb
  import ct_f_spsram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 144
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  clr_req,
  output logic                  init_done,
  input  logic [1:0]            rq_vld,
  output logic [1:0]            rq_rdy,
  input  logic                  rq0_wr,
  input  logic                  rq1_wr,
  input  logic [ADDR_WIDTH-1:0] rq0_addr,
  input  logic [ADDR_WIDTH-1:0] rq1_addr,
  input  logic [DATA_WIDTH-1:0] rq0_wdata,
  input  logic [DATA_WIDTH-1:0] rq1_wdata,
  input  logic [DATA_WIDTH-1:0] rq0_wmask,
  input  logic [DATA_WIDTH-1:0] rq1_wmask,
  output logic [1:0]            rsp_vld,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  state_e                state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;
  logic                  arb_en;
  req_t                  r0, r1, sel;

  assign r0 = '{wr: rq0_wr, addr: rq0_addr,
                wdata: rq0_wdata, wmask: rq0_wmask};
  assign r1 = '{wr: rq1_wr, addr: rq1_addr,
                wdata: rq1_wdata, wmask: rq1_wmask};

  // A clear request steals its own cycle from both requesters.
  assign arb_en = (state == RUN) && !clr_req;

  ct_f_rr_arb2 u_arb (
    .CLK (CLK),
    .RST (RST),
    .en  (arb_en),
    .vld (rq_vld),
    .gnt (rq_rdy)
  );

  assign sel       = rq_rdy[1] ? r1 : r0;
  assign init_done = (state == RUN);
  assign rsp_data  = sram_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= INIT;
      cnt     <= '0;
      rsp_vld <= 2'b00;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      rsp_vld <= rq_rdy & ~{rq1_wr, rq0_wr};
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      INIT: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == {ADDR_WIDTH{1'b1}}) state_nxt = RUN;
      end
      RUN: begin
        if (clr_req) begin
          state_nxt = INIT;
          cnt_nxt   = '0;
        end
      end
    endcase
  end

  always_comb begin
    sram_a    = sel.addr;
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_d    = '0;
    if (!RST) begin
      unique case (state)
        INIT: begin
          sram_a    = cnt;
          sram_cen  = 1'b0;
          sram_gwen = 1'b0;
          sram_wen  = '0;
        end
        RUN: begin
          if (|rq_rdy) begin
            sram_cen  = 1'b0;
            sram_gwen = !sel.wr;
            if (sel.wr) begin
              sram_wen = ~sel.wmask;
              sram_d   = sel.wdata;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ct_f_spsram_512x144_arb.sv
// Self-checking bench for ct_f_spsram_512x144_arb.
// Table vectors, directed clear/reset sequences, random vs memory model.
module tb_ct_f_spsram_512x144_arb;
  import ct_f_spsram_arb_pkg::*;

  localparam int AW = 9;
  localparam int DW = 144;
  localparam logic [DW-1:0] ONES = {DW{1'b1}};

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          clr_req = 1'b0;
  logic          init_done;
  logic [1:0]    rq_vld = 2'b00;
  logic [1:0]    rq_rdy;
  logic          rq0_wr = 1'b0, rq1_wr = 1'b0;
  logic [AW-1:0] rq0_addr = '0, rq1_addr = '0;
  logic [DW-1:0] rq0_wdata = '0, rq1_wdata = '0;
  logic [DW-1:0] rq0_wmask = '0, rq1_wmask = '0;
  logic [1:0]    rsp_vld;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] sram_a;
  logic          sram_cen, sram_gwen;
  logic [DW-1:0] sram_wen, sram_d, sram_q;

  always #5 CLK = ~CLK;

  ct_f_spsram_512x144_arb dut (
    .CLK(CLK), .RST(RST), .clr_req(clr_req),
    .init_done(init_done),
    .rq_vld(rq_vld), .rq_rdy(rq_rdy),
    .rq0_wr(rq0_wr), .rq1_wr(rq1_wr),
    .rq0_addr(rq0_addr), .rq1_addr(rq1_addr),
    .rq0_wdata(rq0_wdata), .rq1_wdata(rq1_wdata),
    .rq0_wmask(rq0_wmask), .rq1_wmask(rq1_wmask),
    .rsp_vld(rsp_vld), .rsp_data(rsp_data),
    .sram_a(sram_a), .sram_cen(sram_cen),
    .sram_gwen(sram_gwen), .sram_wen(sram_wen),
    .sram_d(sram_d), .sram_q(sram_q)
  );

  // SRAM behaviour: write where WEN bit is low, read data next cycle.
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] q;
  assign sram_q = q;
  always @(posedge CLK) begin
    if (!sram_cen) begin
      if (!sram_gwen)
        mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else
        q <= mem[sram_a];
    end
  end

  // Reference: expected contents, favoured requester, pending response.
  logic [DW-1:0] ref_mem [DEPTH];
  logic          fav;
  logic [1:0]    pend_rsp;
  logic [DW-1:0] pend_q;
  int            n_run = 0;
  int            n_fail = 0;

  typedef struct {
    req_t          r0, r1;
    logic [1:0]    vld, erdy, nrsp;
    logic [DW-1:0] nq;
  } vec_t;

  vec_t tbl [17];

  function automatic req_t mk(input logic wr, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input logic [DW-1:0] m);
    req_t r;
    r.wr = wr; r.addr = a; r.wdata = d; r.wmask = m;
    return r;
  endfunction

  function automatic vec_t mv(input logic [1:0] vld,
                              input req_t r0, input req_t r1,
                              input logic [1:0] erdy, input logic [1:0] nrsp,
                              input logic [DW-1:0] nq);
    vec_t v;
    v.vld = vld; v.r0 = r0; v.r1 = r1;
    v.erdy = erdy; v.nrsp = nrsp; v.nq = nq;
    return v;
  endfunction

  function automatic logic [DW-1:0] rnd_dw();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t[DW-1:0];
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input req_t r0, input req_t r1,
                       input logic [1:0] vld, input logic clr);
    rq_vld = vld; clr_req = clr;
    rq0_wr = r0.wr; rq0_addr = r0.addr;
    rq0_wdata = r0.wdata; rq0_wmask = r0.wmask;
    rq1_wr = r1.wr; rq1_addr = r1.addr;
    rq1_wdata = r1.wdata; rq1_wmask = r1.wmask;
  endtask

  task automatic clear_ref();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  // One RUN cycle: check grant/pins now, response of the previous read,
  // then apply the expected grant to the reference.
  task automatic step(input req_t r0, input req_t r1, input logic [1:0] vld,
                      input logic clr, input logic [1:0] erdy,
                      input logic [1:0] nrsp, input logic [DW-1:0] nq,
                      input string nm);
    req_t g;
    @(negedge CLK);
    drive(r0, r1, vld, clr);
    #1;
    chk({nm, "/rdy"}, DW'(rq_rdy), DW'(erdy));
    chk({nm, "/rsp_vld"}, DW'(rsp_vld), DW'(pend_rsp));
    if (pend_rsp != 2'b00) chk({nm, "/rsp_data"}, rsp_data, pend_q);
    g = erdy[1] ? r1 : r0;
    if (erdy == 2'b00) begin
      chk({nm, "/cen_idle"}, DW'(sram_cen), DW'(1'b1));
    end else begin
      chk({nm, "/pins"}, DW'({sram_cen, sram_gwen, sram_a}),
          DW'({1'b0, ~g.wr, g.addr}));
      if (g.wr) begin
        chk({nm, "/wen"}, sram_wen, ~g.wmask);
        chk({nm, "/d"}, sram_d, g.wdata);
      end
    end
    @(posedge CLK);
    if (erdy != 2'b00) begin
      fav = erdy[0];
      if (g.wr)
        ref_mem[g.addr] = (ref_mem[g.addr] & ~g.wmask) | (g.wdata & g.wmask);
    end
    pend_rsp = nrsp;
    pend_q   = nq;
  endtask

  // Called just after a negedge in INIT; counts cycles until init_done
  // and checks the zero-fill address walk on the way.
  task automatic wait_init(input string nm);
    int n;
    int bad;
    n = 0;
    bad = 0;
    while (n < 600) begin
      #1;
      if (init_done === 1'b1) break;
      if (sram_a !== AW'(n) || sram_cen !== 1'b0 || sram_gwen !== 1'b0 ||
          sram_wen !== '0 || sram_d !== '0 || rq_rdy !== 2'b00)
        bad++;
      @(negedge CLK);
      n++;
    end
    // 512 writes, init_done high from the 513th cycle after release
    chk({nm, "/cycles"}, DW'(n), DW'(512));
    chk({nm, "/sweep"}, DW'(bad), DW'(0));
  endtask

  req_t idle;
  req_t a, b, g;
  logic [1:0] v, er, nr;
  logic [DW-1:0] nq;
  int n0, bad;

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle = mk(1'b0, '0, '0, '0);
    fav = 1'b0;
    pend_rsp = 2'b00;
    pend_q = '0;
    clear_ref();

    #2 RST = 1'b1;
    #1;
    chk("rst/cen", DW'(sram_cen), DW'(1'b1));
    chk("rst/gwen", DW'(sram_gwen), DW'(1'b1));
    chk("rst/wen", sram_wen, ONES);
    chk("rst/out", DW'({init_done, rsp_vld, rq_rdy}), DW'(0));
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    wait_init("init");

    step(mk(0, 9'd0, '0, '0), idle, 2'b01, 0, 2'b01, 2'b01, '0, "spot0");
    step(mk(0, 9'd255, '0, '0), idle, 2'b01, 0, 2'b01, 2'b01, '0, "spot255");
    step(mk(0, 9'd511, '0, '0), idle, 2'b01, 0, 2'b01, 2'b01, '0, "spot511");

    // fav is 1 here (requester 0 granted last)
    tbl[0]  = mv(2'b01, mk(1, 9'h1A5, 144'hDEADBEEF00, ONES), idle,
                 2'b01, 2'b00, '0);
    tbl[1]  = mv(2'b01, mk(0, 9'h1A5, '0, '0), idle,
                 2'b01, 2'b01, 144'hDEADBEEF00);
    tbl[2]  = mv(2'b10, idle, mk(1, 9'h020, 144'h5555, ONES),
                 2'b10, 2'b00, '0);
    for (int i = 0; i < 6; i++)
      tbl[3+i] = mv(2'b11, mk(0, 9'h010, '0, '0), mk(0, 9'h020, '0, '0),
                    (i % 2 == 0) ? 2'b01 : 2'b10,
                    (i % 2 == 0) ? 2'b01 : 2'b10,
                    (i % 2 == 0) ? 144'h0 : 144'h5555);
    tbl[9]  = mv(2'b01, mk(1, 9'd5, ONES, 144'hFF), idle, 2'b01, 2'b00, '0);
    tbl[10] = mv(2'b01, mk(0, 9'd5, '0, '0), idle, 2'b01, 2'b01, 144'hFF);
    tbl[11] = mv(2'b00, idle, idle, 2'b00, 2'b00, '0);
    tbl[12] = mv(2'b10, idle, mk(1, 9'd5, ONES, '0), 2'b10, 2'b00, '0);
    tbl[13] = mv(2'b10, idle, mk(0, 9'd5, '0, '0), 2'b10, 2'b10, 144'hFF);
    tbl[14] = mv(2'b11, mk(0, 9'h1A5, '0, '0), mk(1, 9'd5, '0, ONES),
                 2'b01, 2'b01, 144'hDEADBEEF00);
    tbl[15] = mv(2'b11, mk(0, 9'h1A5, '0, '0), mk(1, 9'd5, '0, ONES),
                 2'b10, 2'b00, '0);
    tbl[16] = mv(2'b01, mk(0, 9'd5, '0, '0), idle, 2'b01, 2'b01, '0);

    for (int i = 0; i < 17; i++)
      step(tbl[i].r0, tbl[i].r1, tbl[i].vld, 1'b0, tbl[i].erdy,
           tbl[i].nrsp, tbl[i].nq, $sformatf("vec%0d", i));
    step(idle, idle, 2'b00, 0, 2'b00, 2'b00, '0, "vec_tail");

    // Clear while requester 1 waits; prior read must still respond.
    step(mk(1, 9'd7, 144'h3, ONES), idle, 2'b01, 0, 2'b01, 2'b00, '0, "c_wr");
    step(mk(0, 9'd7, '0, '0), idle, 2'b01, 0, 2'b01, 2'b01, 144'h3, "c_rd");
    step(idle, mk(0, 9'd7, '0, '0), 2'b10, 1, 2'b00, 2'b00, '0, "c_clr");
    clear_ref();
    n0 = 1;
    bad = 0;
    while (n0 < 600) begin
      @(negedge CLK);
      drive(idle, mk(0, 9'd7, '0, '0), 2'b10, 1'b0);
      #1;
      if (rq_rdy === 2'b10) break;
      if (rq_rdy !== 2'b00 || init_done !== 1'b0) bad++;
      n0++;
    end
    chk("clr/stall_cycles", DW'(n0), DW'(513));
    chk("clr/stall_state", DW'(bad), DW'(0));
    @(posedge CLK);
    fav = 1'b0;
    pend_rsp = 2'b10;
    pend_q = '0;
    step(idle, idle, 2'b00, 0, 2'b00, 2'b00, '0, "clr_rd7");

    for (int i = 0; i < 300; i++) begin
      v = 2'($urandom_range(0, 3));
      a = mk(1'($urandom), AW'($urandom_range(0, 15)), rnd_dw(), rnd_dw());
      b = mk(1'($urandom), AW'($urandom_range(0, 15)), rnd_dw(), rnd_dw());
      if ($urandom_range(0, 3) == 0) a.wmask = ONES;
      if ($urandom_range(0, 3) == 0) b.wmask = '0;
      er = (v == 2'b11) ? (fav ? 2'b10 : 2'b01) : v;
      g = er[1] ? b : a;
      nr = (er != 2'b00 && !g.wr) ? er : 2'b00;
      nq = ref_mem[g.addr];
      step(a, b, v, 1'b0, er, nr, nq, $sformatf("rnd%0d", i));
    end
    step(idle, idle, 2'b00, 0, 2'b00, 2'b00, '0, "rnd_tail");

    // Reset in the middle of a sweep.
    step(idle, idle, 2'b00, 1, 2'b00, 2'b00, '0, "r_clr");
    n0 = 0;
    while (n0 < 200) begin
      @(negedge CLK);
      #1;
      if (sram_a === 9'd100) break;
      n0++;
    end
    chk("rst_mid/reach100", DW'(sram_a), DW'(100));
    RST = 1'b1;
    #1;
    chk("rst_mid/idle", DW'({sram_cen, sram_gwen}), DW'(2'b11));
    chk("rst_mid/wen", sram_wen, ONES);
    chk("rst_mid/out", DW'({init_done, rsp_vld}), DW'(0));
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("rst_mid/a0", DW'({sram_cen, sram_a}), DW'(0));
    wait_init("rst_mid");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
